// File: rtl/fmul32_arb_ctrl_if.sv
// Request, datapath and response bundle for fmul32_arb_ctrl.
// The slave modport is the controller side; the master modport is the requester/datapath side.
interface fmul32_arb_ctrl_if;
  logic        r0_valid;
  logic        r0_ready;
  logic [1:0]  r0_op;
  logic [31:0] r0_a;
  logic [31:0] r0_b;
  logic        r1_valid;
  logic        r1_ready;
  logic [1:0]  r1_op;
  logic [31:0] r1_a;
  logic [31:0] r1_b;
  logic [31:0] dp_a;
  logic [31:0] dp_b;
  logic        dp_MUL;
  logic        dp_INV_S;
  logic        dp_ABS_W;
  logic        dp_IDLE;
  logic [31:0] dp_res;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        flush_req;
  logic        flush_done;

  modport master (
    output r0_valid, r0_op, r0_a, r0_b,
    output r1_valid, r1_op, r1_a, r1_b,
    output dp_res, flush_req,
    input  r0_ready, r1_ready,
    input  dp_a, dp_b, dp_MUL, dp_INV_S, dp_ABS_W, dp_IDLE,
    input  resp_valid, resp_id, resp_data, resp_err, flush_done
  );

  modport slave (
    input  r0_valid, r0_op, r0_a, r0_b,
    input  r1_valid, r1_op, r1_a, r1_b,
    input  dp_res, flush_req,
    output r0_ready, r1_ready,
    output dp_a, dp_b, dp_MUL, dp_INV_S, dp_ABS_W, dp_IDLE,
    output resp_valid, resp_id, resp_data, resp_err, flush_done
  );
endinterface

// File: rtl/fmul32_arb_ctrl.sv
// Two-requester round-robin issue controller for a fixed-latency FP datapath, with flush/drain.
// Define FMUL_OPCHK_EN to flag op 11 as an error instead of issuing it as MUL.
//
// state | meaning
// RUN   | arbitrate and issue requests
// DRAIN | no issue; wait for in-flight results to retire
// DONE  | flush_done pulsed on entry; wait for flush_req low
module fmul32_arb_ctrl #(
  parameter int LATENCY = 3
) (
  input  logic             clk,
  input  logic             rst,
  fmul32_arb_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               iss_v_q, iss_v_d;
  logic               iss_id_q, iss_id_d;
  logic               iss_err_q, iss_err_d;
  logic [31:0]        dp_a_q, dp_a_d;
  logic [31:0]        dp_b_q, dp_b_d;
  logic [3:0]         sel_q, sel_d;
  logic [LATENCY-1:0] sr_v_q, sr_v_d;
  logic [LATENCY-1:0] sr_id_q, sr_id_d;
  logic [LATENCY-1:0] sr_err_q, sr_err_d;
  logic               flush_done_q, flush_done_d;

  logic        gnt1, run_ok, xfer, busy;
  logic [1:0]  op_sel;
  logic [31:0] a_sel, b_sel;

  // last_q = 1 means r1 was granted last, so reset favours r0
  assign gnt1   = bus.r1_valid & (~bus.r0_valid | ~last_q);
  assign run_ok = (state_q == RUN) & ~bus.flush_req;
  assign bus.r0_ready = run_ok & ~gnt1;
  assign bus.r1_ready = run_ok & gnt1;
  assign xfer   = (bus.r0_ready & bus.r0_valid) | (bus.r1_ready & bus.r1_valid);
  assign op_sel = gnt1 ? bus.r1_op : bus.r0_op;
  assign a_sel  = gnt1 ? bus.r1_a : bus.r0_a;
  assign b_sel  = gnt1 ? bus.r1_b : bus.r0_b;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    dp_a_d       = dp_a_q;
    dp_b_d       = dp_b_q;
    sel_d        = 4'b0001;
    iss_v_d      = xfer;
    iss_id_d     = gnt1;
    iss_err_d    = 1'b0;
    flush_done_d = 1'b0;
    busy         = iss_v_q;

    if (xfer) begin
      last_d = gnt1;
      dp_a_d = a_sel;
      dp_b_d = b_sel;
      case (op_sel)
        2'b00:   sel_d = 4'b1000;
        2'b01:   sel_d = 4'b0100;
        2'b10:   sel_d = 4'b0010;
        default: begin
`ifdef FMUL_OPCHK_EN
          sel_d     = 4'b0001;
          iss_err_d = 1'b1;
`else
          sel_d     = 4'b1000;
`endif
        end
      endcase
    end

    sr_v_d[0]   = iss_v_q;
    sr_id_d[0]  = iss_id_q;
    sr_err_d[0] = iss_err_q;
    for (int i = 1; i < LATENCY; i++) begin
      sr_v_d[i]   = sr_v_q[i-1];
      sr_id_d[i]  = sr_id_q[i-1];
      sr_err_d[i] = sr_err_q[i-1];
    end

    // the tail retires this cycle, so it does not keep the drain busy
    for (int i = 0; i < LATENCY - 1; i++) busy = busy | sr_v_q[i];

    case (state_q)
      RUN:   if (bus.flush_req) state_d = DRAIN;
      DRAIN: if (!busy) begin
        state_d      = DONE;
        flush_done_d = 1'b1;
      end
      DONE:  if (!bus.flush_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      last_q       <= 1'b1;
      iss_v_q      <= 1'b0;
      iss_id_q     <= 1'b0;
      iss_err_q    <= 1'b0;
      dp_a_q       <= '0;
      dp_b_q       <= '0;
      sel_q        <= 4'b0001;
      sr_v_q       <= '0;
      sr_id_q      <= '0;
      sr_err_q     <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      iss_v_q      <= iss_v_d;
      iss_id_q     <= iss_id_d;
      iss_err_q    <= iss_err_d;
      dp_a_q       <= dp_a_d;
      dp_b_q       <= dp_b_d;
      sel_q        <= sel_d;
      sr_v_q       <= sr_v_d;
      sr_id_q      <= sr_id_d;
      sr_err_q     <= sr_err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign bus.dp_a       = dp_a_q;
  assign bus.dp_b       = dp_b_q;
  assign bus.dp_MUL     = sel_q[3];
  assign bus.dp_INV_S   = sel_q[2];
  assign bus.dp_ABS_W   = sel_q[1];
  assign bus.dp_IDLE    = sel_q[0];
  assign bus.resp_valid = sr_v_q[LATENCY-1];
  assign bus.resp_id    = sr_id_q[LATENCY-1];
  assign bus.resp_err   = sr_v_q[LATENCY-1] & sr_err_q[LATENCY-1];
  assign bus.resp_data  = bus.dp_res;
  assign bus.flush_done = flush_done_q;

endmodule
